// File: rtl/kws_pkg.sv
// Shared widths, saturation limits and the round/shift/saturate quantiser.
// Optional macro PSUM_RELU_EN clamps negative results to zero before saturation.
package kws_pkg;

    localparam int PSUM_W_DEF  = 64;
    localparam int OUT_W_DEF   = 16;
    localparam int SHIFT_W_DEF = 6;

    localparam int OUT_MAX = (1 << (OUT_W_DEF - 1)) - 1;
    localparam int OUT_MIN = -(1 << (OUT_W_DEF - 1));

    localparam logic signed [PSUM_W_DEF-1:0] SAT_HI = PSUM_W_DEF'(OUT_MAX);
    localparam logic signed [PSUM_W_DEF-1:0] SAT_LO = PSUM_W_DEF'(OUT_MIN);

    // Round-half-up, arithmetic shift, optional ReLU, then clamp to OUT_W.
    function automatic logic signed [OUT_W_DEF-1:0] round_shift_sat(
        input logic signed [PSUM_W_DEF-1:0]  sum,
        input logic        [SHIFT_W_DEF-1:0] shift
    );
        logic signed [PSUM_W_DEF-1:0] r;
        logic signed [PSUM_W_DEF-1:0] s;
        r = sum;
        if (shift != '0)
            r = sum + $signed(PSUM_W_DEF'(1) << (shift - SHIFT_W_DEF'(1)));
        s = r >>> shift;
`ifdef PSUM_RELU_EN
        if (s < 0)
            s = '0;
`endif
        if (s > SAT_HI)
            return OUT_W_DEF'(OUT_MAX);
        else if (s < SAT_LO)
            return OUT_W_DEF'(OUT_MIN);
        else
            return s[OUT_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/psum_quant_drain_fifo.sv
// Output FIFO with a registered head: an entry pushed at one edge reaches
// out_valid/out_data at the next edge; push+pop when full both succeed.
module psum_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rptr, wptr, rd_idx;
    logic [AW:0]   count, cnt_left;
    logic          pop, wr;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop      = out_valid & out_ready;
    assign wr       = push & (~full | pop);
    // Head visibility ignores this edge's push so it always lags the write by one cycle.
    assign cnt_left = count - (AW+1)'(pop);
    assign rd_idx   = rptr + AW'(pop);

    always_ff @(posedge clk) begin
        if (wr)
            mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr      <= '0;
            wptr      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clear) begin
            rptr      <= '0;
            wptr      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            rptr      <= rd_idx;
            wptr      <= wptr + AW'(wr);
            count     <= count + (AW+1)'(wr) - (AW+1)'(pop);
            out_valid <= (cnt_left != '0);
            out_data  <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/psum_quant_drain.sv
// PE psum drain: group accumulate, quantise to OUT_W and buffer for the loader.
// Build option PSUM_RELU_EN selects unsigned (ReLU) output.
module psum_quant_drain
    import kws_pkg::*;
#(
    parameter int PSUM_W     = PSUM_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int LEN_W      = 8,
    parameter int SHIFT_W    = SHIFT_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pe_done,
    input  logic signed [PSUM_W-1:0] pe_psum,
    input  logic        [LEN_W-1:0]  cfg_len,
    input  logic        [SHIFT_W-1:0] cfg_shift,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [OUT_W-1:0]  out_data,
    output logic                     overflow,
    output logic                     busy
);
    logic signed [PSUM_W-1:0]  acc, sum;
    logic        [LEN_W-1:0]   cnt, len_sh, len_eff;
    logic        [SHIFT_W-1:0] shift_sh, shift_eff, sum_shift;
    logic                      sum_vld, last, full, empty, drop;
    logic signed [OUT_W-1:0]   q;

    // First psum of a group uses live config; later ones use the captured copy.
    assign len_eff   = (cnt == '0) ? cfg_len   : len_sh;
    assign shift_eff = (cnt == '0) ? cfg_shift : shift_sh;
    assign last      = (len_eff == '0) || (cnt >= len_eff - LEN_W'(1));

    assign q    = round_shift_sat(sum, sum_shift);
    assign drop = sum_vld & full & ~(out_valid & out_ready);
    assign busy = (cnt != '0) | sum_vld | ~empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            cnt       <= '0;
            len_sh    <= '0;
            shift_sh  <= '0;
            sum       <= '0;
            sum_shift <= '0;
            sum_vld   <= 1'b0;
            overflow  <= 1'b0;
        end else if (clear) begin
            acc      <= '0;
            cnt      <= '0;
            sum_vld  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            sum_vld <= 1'b0;
            if (pe_done) begin
                if (cnt == '0) begin
                    len_sh   <= cfg_len;
                    shift_sh <= cfg_shift;
                end
                if (last) begin
                    sum       <= acc + pe_psum;
                    sum_shift <= shift_eff;
                    sum_vld   <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= acc + pe_psum;
                    cnt <= cnt + LEN_W'(1);
                end
            end
            if (drop)
                overflow <= 1'b1;
        end
    end

    psum_fifo #(
        .W     (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .push      (sum_vld),
        .din       (q),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_psum_quant_drain.sv
// Directed bench for psum_quant_drain: quantiser vector table plus grouping,
// FIFO overflow, clear and reset sequences.
module tb_psum_quant_drain;

`ifdef PSUM_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic               clk, reset, pe_done, clear, out_valid, out_ready, overflow, busy;
    logic signed [63:0] pe_psum;
    logic [7:0]         cfg_len;
    logic [5:0]         cfg_shift;
    logic [15:0]        out_data;

    int checks = 0;
    int errors = 0;

    psum_quant_drain dut (
        .clk       (clk),
        .reset     (reset),
        .pe_done   (pe_done),
        .pe_psum   (pe_psum),
        .cfg_len   (cfg_len),
        .cfg_shift (cfg_shift),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int     len;
        int     shift;
        longint psum;
        int     exp;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic done_psum(input longint v);
        pe_done = 1'b1;
        pe_psum = v;
        tick();
        pe_done = 1'b0;
    endtask

    function automatic longint sdata();
        return longint'($signed(out_data));
    endfunction

    initial begin
        vecs[0]  = '{1, 4, 24, 2};
        vecs[1]  = '{1, 4, -24, RELU ? 0 : -1};
        vecs[2]  = '{1, 0, 40000, 32767};
        vecs[3]  = '{1, 0, -40000, RELU ? 0 : -32768};
        vecs[4]  = '{0, 0, 100, 100};
        vecs[5]  = '{1, 1, 7, 4};
        vecs[6]  = '{0, 1, -7, RELU ? 0 : -3};
        vecs[7]  = '{1, 2, 5, 1};
        vecs[8]  = '{1, 2, 6, 2};
        vecs[9]  = '{1, 2, -6, RELU ? 0 : -1};
        vecs[10] = '{1, 0, 32767, 32767};
        vecs[11] = '{1, 0, 32768, 32767};
        vecs[12] = '{1, 0, -32768, RELU ? 0 : -32768};
        vecs[13] = '{1, 30, 64'sd1 << 40, 1024};
        vecs[14] = '{1, 63, -1, 0};
        vecs[15] = '{1, 3, -32, RELU ? 0 : -4};

        reset = 1'b0; pe_done = 1'b0; pe_psum = '0; cfg_len = 8'd1; cfg_shift = '0;
        clear = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Single-psum groups through the quantiser
        foreach (vecs[i]) begin
            cfg_len   = 8'(vecs[i].len);
            cfg_shift = 6'(vecs[i].shift);
            out_ready = 1'b0;
            done_psum(vecs[i].psum);
            tick();
            chk($sformatf("vec%0d_early", i), out_valid, 0);
            tick();
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_data", i), sdata(), vecs[i].exp);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("vec%0d_popped", i), out_valid, 0);
            chk($sformatf("vec%0d_idle", i), busy, 0);
        end

        // len=4 group; mid-group cfg_len change must be ignored
        cfg_len = 8'd4; cfg_shift = '0; out_ready = 1'b1;
        done_psum(10);
        chk("grp_busy", busy, 1);
        cfg_len = 8'd2;
        done_psum(20);
        done_psum(30);
        done_psum(40);
        chk("grp_n0", out_valid, 0);
        tick();
        chk("grp_n1", out_valid, 0);
        tick();
        chk("grp_valid", out_valid, 1);
        chk("grp_data", sdata(), 100);
        tick();
        chk("grp_pop", out_valid, 0);

        // Five results into a four-deep FIFO with consumer stalled
        cfg_len = 8'd1; out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) done_psum(k);
        tick();
        tick();
        chk("ovf_flag", overflow, 1);
        chk("ovf_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ovf_pop%0d", k), sdata(), k);
            tick();
        end
        out_ready = 1'b0;
        chk("ovf_empty", out_valid, 0);
        chk("ovf_idle", busy, 0);
        chk("ovf_sticky", overflow, 1);

        // Clear mid-group with a coincident pe_done
        cfg_len = 8'd4; out_ready = 1'b1;
        done_psum(100);
        done_psum(100);
        clear = 1'b1; pe_done = 1'b1; pe_psum = 999;
        tick();
        clear = 1'b0; pe_done = 1'b0;
        chk("clr_ovf", overflow, 0);
        chk("clr_busy", busy, 0);
        chk("clr_valid", out_valid, 0);
        for (int k = 0; k < 4; k++) done_psum(1);
        tick();
        tick();
        chk("clr_valid2", out_valid, 1);
        chk("clr_data", sdata(), 4);
        tick();

        // Back-to-back len-1 groups stream one result per cycle
        cfg_len = 8'd1; out_ready = 1'b1;
        pe_done = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            pe_psum = k;
            tick();
        end
        pe_done = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("str_valid%0d", k), out_valid, 1);
            chk($sformatf("str_data%0d", k), sdata(), k);
            tick();
        end
        chk("str_end", out_valid, 0);

        // Async reset with a buffered result and a partial group
        out_ready = 1'b0; cfg_len = 8'd1;
        done_psum(9);
        tick();
        tick();
        chk("rmid_pre", out_valid, 1);
        cfg_len = 8'd3;
        done_psum(5);
        done_psum(5);
        #2 reset = 1'b0;
        #1;
        chk("rmid_valid", out_valid, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_data", out_data, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        cfg_len = 8'd2; out_ready = 1'b1;
        done_psum(3);
        done_psum(4);
        tick();
        tick();
        chk("rmid_after_valid", out_valid, 1);
        chk("rmid_after_data", sdata(), 7);
        tick();
        chk("rmid_after_pop", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
